// File: rtl/pad_io_pkg.sv
// -----------------------------------------------------------------------------
// pad_io_pkg
// Shared helpers for the pad-side I/O bridge.
//   clog2      : ceiling log2, used for FIFO address/pointer widths
//   beats      : number of pad beats per core word (width / pads)
//   cnt_width  : counter width for a beat counter (at least 1 bit)
//   cfg_ok     : parameter sanity check (divisibility, power-of-2 FIFO depth)
//   des_state_e: deserialiser FSM states
// -----------------------------------------------------------------------------
package pad_io_pkg;

    typedef enum logic {
        DES_IDLE = 1'b0,   // waiting for a captured sof
        DES_FILL = 1'b1    // slot 0 written, filling the remaining slots
    } des_state_e;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << result) < value) begin
                result = result + 1;
            end
        end
        return result;
    endfunction

    function automatic int beats(input int width, input int pads);
        return width / pads;
    endfunction

    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : clog2(n);
    endfunction

    function automatic bit cfg_ok(input int in_w, input int in_pads,
                                  input int out_w, input int out_pads,
                                  input int depth);
        return (in_pads > 0) && (out_pads > 0) &&
               (in_w >= in_pads) && (out_w >= out_pads) &&
               ((in_w % in_pads) == 0) && ((out_w % out_pads) == 0) &&
               (depth >= 2) && ((depth & (depth - 1)) == 0);
    endfunction

endpackage

// File: rtl/pad_io_fifo.sv
// -----------------------------------------------------------------------------
// pad_io_fifo
// Synchronous FIFO with combinational read of the head entry.
//   clk, rst : clock, synchronous active-high reset (empties the FIFO)
//   push     : write wdata; accepted when not full, or when full with a pop
//   wdata    : data to write
//   pop      : remove the head entry; ignored when empty
//   rdata    : head entry (meaningful only while !empty)
//   full     : DEPTH entries stored
//   empty    : no entries stored
// Pointers carry one extra wrap bit so full and empty are distinguishable.
// -----------------------------------------------------------------------------
module pad_io_fifo
    import pad_io_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             wr_en;
    logic             rd_en;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rd_en = pop && !empty;
    // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
    assign wr_en = push && (!full || rd_en);
    assign rdata = mem[rd_ptr[AW-1:0]];

    // NOTE: sequential state is assigned with <= so every flop samples the
    // pre-edge value of every other flop, independent of block ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + PW'(1);
            if (rd_en) rd_ptr <= rd_ptr + PW'(1);
        end
    end

    // NOTE: the storage array has no reset; the pointers alone define which
    // entries are valid, so clearing the data would only cost flops.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/pad_io_serdes.sv
// -----------------------------------------------------------------------------
// pad_io_serdes
// Pad-side bridge between the chip pads and the Viterbi decoder core.
// Input path : pads are registered once, then deserialised IN_BEATS beats per
//              core symbol (LSB slice first, framed by pad_in_sof).
// Output path: decoded words are queued in a FIFO and serialised OUT_BEATS
//              beats per word onto the output pads (LSB slice first).
// Ports
//   clk, rst       : single clock, synchronous active-high reset
//   pad_in_data    : input pad beat          pad_in_sof    : beat 0 marker
//   core_in_data   : assembled symbol        core_in_valid : 1-cycle pulse
//   core_out_data  : decoded word            core_out_valid: FIFO push strobe
//   pad_out_data   : output pad beat         pad_out_valid : beat valid
//   pad_out_sof    : beat 0 of a word
//   overflow       : sticky, a word was dropped because the FIFO was full
//   err_frame      : sticky, sof arrived inside a partial input frame
// -----------------------------------------------------------------------------
module pad_io_serdes
    import pad_io_pkg::*;
#(
    parameter int IN_W       = 16,
    parameter int IN_PADS    = 8,
    parameter int OUT_W      = 8,
    parameter int OUT_PADS   = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [IN_PADS-1:0]  pad_in_data,
    input  logic                pad_in_sof,
    output logic [IN_W-1:0]     core_in_data,
    output logic                core_in_valid,
    input  logic [OUT_W-1:0]    core_out_data,
    input  logic                core_out_valid,
    output logic [OUT_PADS-1:0] pad_out_data,
    output logic                pad_out_valid,
    output logic                pad_out_sof,
    output logic                overflow,
    output logic                err_frame
);

    localparam int IN_BEATS  = beats(IN_W, IN_PADS);
    localparam int OUT_BEATS = beats(OUT_W, OUT_PADS);
    localparam int IN_CW     = cnt_width(IN_BEATS);
    localparam int OUT_CW    = cnt_width(OUT_BEATS);
    localparam logic [IN_CW-1:0]  IN_LAST  = IN_CW'(IN_BEATS - 1);
    localparam logic [OUT_CW-1:0] OUT_LAST = OUT_CW'(OUT_BEATS - 1);

    if (!cfg_ok(IN_W, IN_PADS, OUT_W, OUT_PADS, FIFO_DEPTH)) begin : g_cfg_error
        $error("pad_io_serdes: widths must be multiples of pad counts and FIFO_DEPTH a power of 2 >= 2");
    end

    // ------------------------------------------------------------------------
    // Input capture stage
    // ------------------------------------------------------------------------
    logic [IN_PADS-1:0] cap_data;
    logic               cap_sof;

    always_ff @(posedge clk) begin
        if (rst) begin
            cap_data <= '0;
            cap_sof  <= 1'b0;
        end else begin
            cap_data <= pad_in_data;
            cap_sof  <= pad_in_sof;
        end
    end

    // ------------------------------------------------------------------------
    // Deserialiser FSM: state register / next-state / output decode
    // ------------------------------------------------------------------------
    des_state_e       state_q;
    des_state_e       state_d;
    logic [IN_CW-1:0] cnt_q;
    logic [IN_CW-1:0] cnt_d;
    logic [IN_W-1:0]  asm_q;
    logic [IN_W-1:0]  asm_d;
    logic             take_beat;
    logic [IN_CW-1:0] slot;
    logic             word_done;
    logic             frame_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= DES_IDLE;
            cnt_q         <= '0;
            asm_q         <= '0;
            core_in_data  <= '0;
            core_in_valid <= 1'b0;
            err_frame     <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            asm_q         <= asm_d;
            core_in_valid <= word_done;
            if (word_done) core_in_data <= asm_d;
            if (frame_err) err_frame <= 1'b1;
        end
    end

    // NOTE: every variable driven here gets a default before the case, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            DES_IDLE: begin
                if (cap_sof && (IN_BEATS > 1)) begin
                    state_d = DES_FILL;
                    cnt_d   = IN_CW'(1);
                end
            end
            DES_FILL: begin
                if (cap_sof) begin
                    // Restart: the sof beat becomes slot 0 of a new word.
                    cnt_d = IN_CW'(1);
                end else if (cnt_q == IN_LAST) begin
                    state_d = DES_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + IN_CW'(1);
                end
            end
            default: begin
                state_d = DES_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        take_beat = 1'b0;
        slot      = '0;
        word_done = 1'b0;
        frame_err = 1'b0;
        case (state_q)
            DES_IDLE: begin
                // Non-sof beats outside a frame are ignored.
                if (cap_sof) begin
                    take_beat = 1'b1;
                    word_done = (IN_BEATS == 1);
                end
            end
            DES_FILL: begin
                take_beat = 1'b1;
                if (cap_sof) begin
                    frame_err = 1'b1;
                end else begin
                    slot      = cnt_q;
                    word_done = (cnt_q == IN_LAST);
                end
            end
            default: ;
        endcase
    end

    // The word completes in the same edge that stores its last slice, which
    // keeps pad-to-core latency at two cycles.
    always_comb begin
        asm_d = asm_q;
        if (take_beat) asm_d[int'(slot) * IN_PADS +: IN_PADS] = cap_data;
    end

    // ------------------------------------------------------------------------
    // Output FIFO
    // ------------------------------------------------------------------------
    logic [OUT_W-1:0] fifo_rdata;
    logic             fifo_full;
    logic             fifo_empty;
    logic             ser_pop;

    pad_io_fifo #(
        .WIDTH (OUT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (core_out_valid),
        .wdata (core_out_data),
        .pop   (ser_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (core_out_valid && fifo_full && !ser_pop) begin
            overflow <= 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Serialiser
    // ------------------------------------------------------------------------
    logic [OUT_CW-1:0] beat_q;
    logic [OUT_CW-1:0] beat_nxt;
    logic [OUT_W-1:0]  word_q;

    // Popping on the last beat as well as when idle lets words run back to back.
    assign ser_pop  = (!pad_out_valid || (beat_q == OUT_LAST)) && !fifo_empty;
    assign beat_nxt = beat_q + OUT_CW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            beat_q        <= '0;
            word_q        <= '0;
            pad_out_data  <= '0;
            pad_out_valid <= 1'b0;
            pad_out_sof   <= 1'b0;
        end else if (ser_pop) begin
            beat_q        <= '0;
            word_q        <= fifo_rdata;
            pad_out_data  <= fifo_rdata[OUT_PADS-1:0];
            pad_out_valid <= 1'b1;
            pad_out_sof   <= 1'b1;
        end else if (pad_out_valid && (beat_q != OUT_LAST)) begin
            beat_q        <= beat_nxt;
            pad_out_data  <= word_q[int'(beat_nxt) * OUT_PADS +: OUT_PADS];
            pad_out_sof   <= 1'b0;
        end else begin
            beat_q        <= '0;
            pad_out_data  <= '0;
            pad_out_valid <= 1'b0;
            pad_out_sof   <= 1'b0;
        end
    end

endmodule
